// File: rtl/sha256_seq_pkg.sv
// Shared types and constants for the SHA-256 message sequencer and its digest unloader.
package sha256_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ABSORB,
      ST_PAD,
      ST_START,
      ST_WAIT,
      ST_OUT
   } seq_state_t;

   localparam logic [7:0] PAD_BYTE     = 8'h80;
   localparam int         LEN_POS      = 56;
   localparam int         BLOCK_BYTES  = 64;
   localparam int         DIGEST_BYTES = 32;

endpackage

// File: rtl/sha256_digest_unloader.sv
// Streams the eight 32-bit digest words out one byte per cycle, most significant byte first.
module sha256_digest_unloader
   import sha256_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] h_data,
   output logic [2:0]  h_addr,
   output logic [7:0]  dout,
   output logic        dvalid,
   output logic        done
);

   logic [4:0] out_idx;
   logic       active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_idx <= '0;
         active  <= 1'b0;
      end else if (go) begin
         out_idx <= '0;
         active  <= 1'b1;
      end else if (active) begin
         if (out_idx == 5'(DIGEST_BYTES - 1))
            active <= 1'b0;
         out_idx <= out_idx + 5'd1;
      end
   end

   assign h_addr = out_idx[4:2];
   assign dvalid = active;
   assign done   = active && (out_idx == 5'(DIGEST_BYTES - 1));

   // dout is held at zero outside the 32-cycle window so idle outputs stay quiet
   always_comb begin
      dout = 8'h00;
      if (active) begin
         case (out_idx[1:0])
            2'd0:    dout = h_data[31:24];
            2'd1:    dout = h_data[23:16];
            2'd2:    dout = h_data[15:8];
            default: dout = h_data[7:0];
         endcase
      end
   end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Packs the input byte stream into 512-bit blocks, appends SHA-256 padding and length,
// drives the compression core once per block and finally unloads the digest.
module sha256_msg_sequencer
   import sha256_seq_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic        valid,
   input  logic        last,
   output logic        busy,
   output logic [7:0]  dout,
   output logic        dvalid,
   output logic        w_we,
   output logic [3:0]  w_addr,
   output logic [31:0] w_data,
   output logic        core_start,
   output logic        core_init,
   input  logic        core_done,
   output logic [2:0]  h_addr,
   input  logic [31:0] h_data
);

   seq_state_t       state, state_next;
   logic [5:0]       byte_idx;
   logic [LEN_W-1:0] msg_cnt;
   logic [23:0]      hold;
   logic             first_blk, need_80, final_blk, pad_sent;

   logic             accept, strobe, in_pad, go, unl_done;
   logic [7:0]       pbyte, pad_val, len_byte;
   logic [63:0]      len_bits;

   assign accept = valid && ((state == ST_IDLE) || (state == ST_ABSORB));
   assign busy   = !((state == ST_IDLE) || (state == ST_ABSORB));
   assign in_pad = (state == ST_PAD);
   assign strobe = accept || in_pad;

   assign len_bits = {{(61 - LEN_W){1'b0}}, msg_cnt, 3'b000};

   // Length bytes occupy positions 56..63, most significant byte first
   always_comb begin
      len_byte = 8'h00;
      case (byte_idx[2:0])
         3'd0:    len_byte = len_bits[63:56];
         3'd1:    len_byte = len_bits[55:48];
         3'd2:    len_byte = len_bits[47:40];
         3'd3:    len_byte = len_bits[39:32];
         3'd4:    len_byte = len_bits[31:24];
         3'd5:    len_byte = len_bits[23:16];
         3'd6:    len_byte = len_bits[15:8];
         default: len_byte = len_bits[7:0];
      endcase
   end

   always_comb begin
      pad_val = 8'h00;
      if (need_80)
         pad_val = PAD_BYTE;
      else if (final_blk && (byte_idx >= 6'(LEN_POS)))
         pad_val = len_byte;
   end

   assign pbyte      = in_pad ? pad_val : din;
   assign w_we       = strobe && (byte_idx[1:0] == 2'b11);
   assign w_addr     = byte_idx[5:2];
   assign w_data     = w_we ? {hold, pbyte} : 32'h0;
   assign core_start = (state == ST_START);
   assign core_init  = core_start && first_blk;
   assign go         = (state == ST_WAIT) && core_done && final_blk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_ABSORB: begin
            if (accept) begin
               if (byte_idx == 6'(BLOCK_BYTES - 1))
                  state_next = ST_START;
               else if (last)
                  state_next = ST_PAD;
               else
                  state_next = ST_ABSORB;
            end
         end
         ST_PAD: begin
            if (byte_idx == 6'(BLOCK_BYTES - 1))
               state_next = ST_START;
         end
         ST_START: state_next = ST_WAIT;
         ST_WAIT: begin
            if (core_done) begin
               if (final_blk)
                  state_next = ST_OUT;
               else if (need_80 || pad_sent)
                  state_next = ST_PAD;
               else
                  state_next = ST_ABSORB;
            end
         end
         ST_OUT: begin
            if (unl_done)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // byte_idx wraps 63 -> 0 on its own, so every new block starts at position 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx  <= '0;
         msg_cnt   <= '0;
         hold      <= '0;
         first_blk <= 1'b0;
         need_80   <= 1'b0;
         final_blk <= 1'b0;
         pad_sent  <= 1'b0;
      end else begin
         if (strobe) begin
            hold     <= {hold[15:0], pbyte};
            byte_idx <= byte_idx + 6'd1;
         end
         if (accept) begin
            msg_cnt <= msg_cnt + 1'b1;
            if (state == ST_IDLE)
               first_blk <= 1'b1;
            if (last)
               need_80 <= 1'b1;
         end
         if (in_pad && need_80) begin
            need_80  <= 1'b0;
            pad_sent <= 1'b1;
            if (byte_idx < 6'(LEN_POS))
               final_blk <= 1'b1;
         end
         if (state == ST_START)
            first_blk <= 1'b0;
         // 0x80 spilled past position 55: the fresh block after it carries the length
         if ((state == ST_WAIT) && core_done && !final_blk && pad_sent)
            final_blk <= 1'b1;
         if ((state == ST_OUT) && unl_done) begin
            msg_cnt   <= '0;
            byte_idx  <= '0;
            hold      <= '0;
            final_blk <= 1'b0;
            pad_sent  <= 1'b0;
         end
      end
   end

   sha256_digest_unloader u_unloader (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .h_data (h_data),
      .h_addr (h_addr),
      .dout   (dout),
      .dvalid (dvalid),
      .done   (unl_done)
   );

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Randomized bench: a FIPS 180-4 padding model and a mock compression core check blocks and digest.
module tb_sha256_msg_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic        valid, last;
   logic        busy;
   logic [7:0]  dout;
   logic        dvalid;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [31:0] w_data;
   logic        core_start, core_init, core_done;
   logic [2:0]  h_addr;
   logic [31:0] h_data;

   always #5 clk = ~clk;

   sha256_msg_sequencer #(.LEN_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .valid      (valid),
      .last       (last),
      .busy       (busy),
      .dout       (dout),
      .dvalid     (dvalid),
      .w_we       (w_we),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .core_start (core_start),
      .core_init  (core_init),
      .core_done  (core_done),
      .h_addr     (h_addr),
      .h_data     (h_data)
   );

   logic [31:0] h_words [8] = '{32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                                32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};
   assign h_data = h_words[h_addr];

   int          errors = 0;
   int          checks = 0;

   logic [7:0]  msg     [256];
   logic [7:0]  exp_pad [512];
   int          exp_blocks;
   logic [31:0] wbuf    [16];
   int          blk_no;
   logic [7:0]  dig     [32];
   int          dig_cnt, dig_first, dig_last;
   int          cyc = 0;
   bit          stall = 1'b0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference padding: message, 0x80, zeros up to 56 mod 64, then 64-bit big-endian bit length
   task automatic build_model(input int n);
      logic [63:0] bitlen;
      exp_blocks = (n + 8) / 64 + 1;
      for (int i = 0; i < 512; i++)
         exp_pad[i] = 8'h00;
      for (int i = 0; i < n; i++)
         exp_pad[i] = msg[i];
      exp_pad[n] = 8'h80;
      bitlen = 64'(n) * 64'd8;
      for (int k = 0; k < 8; k++)
         exp_pad[exp_blocks * 64 - 8 + k] = 8'((bitlen >> (56 - 8 * k)) & 64'hFF);
   endtask

   // Monitor: shadow the block buffer, compare it at every core_start, collect the digest
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (w_we)
               wbuf[w_addr] = w_data;
            if (core_start) begin
               if (blk_no < 7) begin
                  for (int w = 0; w < 16; w++) begin
                     int b;
                     b = blk_no * 64 + w * 4;
                     checkOutput($sformatf("blk%0d_w%0d", blk_no, w), 64'(wbuf[w]),
                                 64'({exp_pad[b], exp_pad[b+1], exp_pad[b+2], exp_pad[b+3]}));
                  end
               end
               checkOutput($sformatf("core_init_blk%0d", blk_no), 64'(core_init), 64'(blk_no == 0));
               blk_no++;
            end
            if (dvalid) begin
               if (dig_cnt < 32)
                  dig[dig_cnt] = dout;
               if (dig_cnt == 0)
                  dig_first = cyc;
               dig_last = cyc;
               dig_cnt++;
            end
         end
      end
   end

   // Mock compression core with a random 1..4 cycle latency
   initial begin
      int lat;
      core_done = 1'b0;
      forever begin
         @(negedge clk);
         if (core_start && !stall && rst_n) begin
            lat = $urandom_range(1, 4);
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1 core_done = 1'b1;
            @(posedge clk);
            #1 core_done = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input int n, input bit expect_digest);
      int  i, cycles;
      bit  sent;
      build_model(n);
      blk_no  = 0;
      dig_cnt = 0;
      i       = 0;
      cycles  = 0;
      while (i < n && cycles < 5000) begin
         if (busy) begin
            valid = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
            last  = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 3) == 0) begin
            valid = 1'b0;
            din   = 8'($urandom);
            last  = 1'($urandom_range(0, 1));
         end else begin
            valid = 1'b1;
            din   = msg[i];
            last  = (i == n - 1);
         end
         sent = valid && !busy;
         @(posedge clk);
         #1;
         cycles++;
         if (sent) begin
            if (i == n - 1)
               checkOutput("busy_after_last", 64'(busy), 64'd1);
            i++;
         end
      end
      valid = 1'b0;
      last  = 1'b0;
      if (i < n)
         checkOutput("accept_timeout", 64'(i), 64'(n));
      if (expect_digest) begin
         cycles = 0;
         while (dig_cnt < 32 && cycles < 3000) begin
            if (busy) begin
               valid = 1'($urandom_range(0, 1));
               din   = 8'($urandom);
               last  = 1'($urandom_range(0, 1));
            end else begin
               valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
         end
         valid = 1'b0;
         last  = 1'b0;
         checkOutput("dig_count", 64'(dig_cnt), 64'd32);
         checkOutput("idle_busy", 64'(busy), 64'd0);
         checkOutput("idle_dvalid", 64'(dvalid), 64'd0);
         checkOutput("block_count", 64'(blk_no), 64'(exp_blocks));
         checkOutput("dvalid_span", 64'(dig_last - dig_first), 64'd31);
         for (int k = 0; k < 32; k++)
            checkOutput($sformatf("digest_b%0d", k), 64'(dig[k]),
                        64'((h_words[k / 4] >> (8 * (3 - (k % 4)))) & 32'hFF));
      end
   endtask

   task automatic load_abc();
      msg[0] = 8'h61;
      msg[1] = 8'h62;
      msg[2] = 8'h63;
   endtask

   task automatic load_random(input int n);
      for (int i = 0; i < n; i++)
         msg[i] = 8'($urandom);
   endtask

   initial begin
      int n, cycles;
      rst_n = 1'b0;
      valid = 1'b0;
      last  = 1'b0;
      din   = 8'h00;
      blk_no  = 0;
      dig_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_outputs",
                  64'({dvalid, dout, core_start, core_init, w_we, w_addr, h_addr}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      load_abc();
      applyStimulus(3, 1'b1);
      load_random(55);
      applyStimulus(55, 1'b1);
      load_random(56);
      applyStimulus(56, 1'b1);
      load_random(64);
      applyStimulus(64, 1'b1);
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 200);
         load_random(n);
         applyStimulus(n, 1'b1);
      end

      // Abort while the core is working on the block, then rerun "abc"
      stall = 1'b1;
      load_abc();
      applyStimulus(3, 1'b0);
      cycles = 0;
      while (blk_no < 1 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("wait_reached", 64'(blk_no), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_outputs",
                  64'({dvalid, dout, core_start, core_init, w_we, w_addr, w_data, h_addr}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stall = 1'b0;
      @(posedge clk);
      #1;
      load_abc();
      applyStimulus(3, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Message sequencer for the SHA-256 engine: accepts the GPIO byte stream (data, valid, last), packs bytes big-endian into the compression core's 16-word block buffer, and appends FIPS 180-4 padding and the 64-bit bit length. It starts the core once per 512-bit block and waits for completion. After the final block it streams the 32-byte digest out one byte per cycle. It sits between the pin-level wrapper and the compression core, and owns all block and padding sequencing.

## Interface
Parameters:
- LEN_W, 32, width of the message byte counter; bit length = {count, 3'b000} zero-extended to 64 bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  message byte
- valid  in  1  din valid; accepted when valid && !busy
- last  in  1  qualified by valid; marks the final message byte
- busy  out  1  byte input not accepted
- dout  out  8  digest byte
- dvalid  out  1  dout valid
- w_we  out  1  block-buffer word write strobe
- w_addr  out  4  word index 0..15
- w_data  out  32  word, first byte in [31:24]
- core_start  out  1  one-cycle pulse: compress buffered block
- core_init  out  1  valid with core_start; 1 = load IV before this block
- core_done  in  1  one-cycle pulse: block compressed
- h_addr  out  3  digest word select H0..H7
- h_data  in  32  selected digest word, combinational read

## Operation
- States: IDLE, ABSORB, PAD, START, WAIT, OUT.
- Counters: byte_idx[5:0] (position in block); msg_cnt[LEN_W-1:0] (bytes accepted); out_idx[4:0].
- Flags: first_blk, need_80, final_blk.
- IDLE/ABSORB: busy=0. An accepted byte is shifted into a 24-bit holding register.
  - When byte_idx[1:0]==3, the same cycle asserts w_we, w_addr=byte_idx[5:2], w_data={hold,din}.
  - IDLE moves to ABSORB on the first accept and sets first_blk=1.
- Accept with byte_idx==63 and !last: go to START. The block is not final.
- Accept with last:
  - set need_80=1;
  - if byte_idx==63, go to START (non-final), then PAD;
  - otherwise go to PAD.
- PAD emits one internal byte per cycle at byte_idx through the same packing path:
  - 0x80 if need_80; writing it clears need_80;
  - final_blk is set when 0x80 lands at position ≤55, or when PAD starts a fresh block after 0x80 was already written;
  - length byte (idx−56), big-endian, if final_blk and idx≥56;
  - else 0x00;
  - at idx 63, go to START.
- START: core_start=1 and core_init=first_blk; then clear first_blk and go to WAIT.
- WAIT, on core_done:
  - final_blk set: go to OUT;
  - padding pending: go to PAD;
  - otherwise: go to ABSORB with byte_idx=0.
- OUT: h_addr=out_idx[4:2]; dout=h_data byte (3−out_idx[1:0]); dvalid=1. After out_idx 31, go to IDLE and clear msg_cnt.
- busy = state∉{IDLE,ABSORB}, decoded from the state register.
- Not supported: empty messages and messages of 2^LEN_W bytes or more (msg_cnt wraps silently).
- valid while busy is ignored, not queued. core_done outside WAIT is ignored.

## Timing
- Reset values: all outputs 0 (busy=0, dvalid=0, core_start=0, h_addr=0). State IDLE, all counters and flags cleared.
- Reset mid-operation aborts immediately. The next message starts with core_init=1. The core shares rst_n.
- Word write occurs in the cycle of the 4th byte's acceptance (or PAD cycle), with zero latency.
- Block full or last byte at cycle t:
  - busy=1 from t+1;
  - core_start at t+1 when the block is full;
  - the first PAD byte at t+1 when padding is required.
- PAD costs 64−(position of first pad byte) cycles per block.
- core_start to core_done latency is arbitrary, ≥1 cycle.
- core_done at t: OUT at t+1 with dvalid high for exactly 32 consecutive cycles; IDLE and busy=0 at t+33.

## Structure
- Package sha256_seq_pkg holds:
  - state enum;
  - PAD_BYTE=8'h80, LEN_POS=56, BLOCK_BYTES=64, DIGEST_BYTES=32.
- One sub-module, sha256_digest_unloader:
  - out_idx counter, h_addr and byte mux, dvalid;
  - started by a one-cycle go pulse; returns done.
- Byte packing and padding logic stay in the top FSM.

## Test plan
- "abc" (61,62,63, last on 63): one block; word0=0x61626380, words1–14=0, word15=0x00000018; single core_start with core_init=1.
- 55-byte message: single block with 0x80 at byte 55; word15=0x000001B8.
- 56-byte message: block1 has 0x80 at byte 56, rest zero, final_blk=0; block2 words0–13=0, word15=0x000001C0; core_init 1 then 0.
- 64-byte message: block1 is data only; block2 word0=0x80000000, word15=0x00000200; ≥1 idle cycle between each core_start and core_done tolerated.
- Mock core H0=0xBA7816BF…H7=0xF20015AD: dout sequence BA,78,16,BF,…,AD over 32 consecutive dvalid cycles; bytes driven with valid while busy do not change msg_cnt.
- rst_n low during WAIT: all outputs 0 asynchronously. Then "abc" again gives core_init=1 and a digest identical to the first test.
